key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 20 ++
 rtl/key_sync2.sv | 26 ++
 rtl/key_debounce.sv | 170 +++++++++++++++++
 tb/tb_key_debounce.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } key_state_e;

    // Defaults assume a 50 MHz clock: 20 ms debounce, 0.5 s hold, 0.1 s repeat.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
    localparam int unsigned DEF_HOLD_CYCLES     = 32'd25000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 32'd5000000;

    function automatic logic is_pressed_state(input key_state_e st);
        return (st == PRESSED) || (st == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer for an active-low asynchronous input; both flops
// reset to the inactive (high) level.
module key_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability-settling chain into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with registered level and press/release strobes.
// Define KEY_DEBOUNCE_REPEAT_EN to add hold-to-auto-repeat press strobes.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic CLOCK_50,
    input  logic KEY0,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    if ((DEBOUNCE_CYCLES < 32'd2) || (HOLD_CYCLES < 32'd1) || (REPEAT_CYCLES < 32'd1)) begin : g_param_check
        $error("key_debounce: cycle parameters out of range");
    end

    logic             sync_n_s;
    key_state_e       state_r;
    key_state_e       state_n_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n_s;
    logic             press_set_s;
    logic             release_set_s;
    logic             rep_fire_s;
    logic             pressed_r;
    logic             press_pulse_r;
    logic             release_pulse_r;

    key_sync2 u_sync (
        .clk   (CLOCK_50),
        .rst_n (KEY0),
        .d     (key_n),
        .q     (sync_n_s)
    );

    // State and debounce counter registers.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Next-state logic; the counter is cleared on every state entry so it never wraps.
    always_comb begin
        state_n_s     = state_r;
        cnt_n_s       = cnt_r;
        press_set_s   = 1'b0;
        release_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!sync_n_s) begin
                    state_n_s = PRESS_WAIT;
                    cnt_n_s   = {CNT_W{1'b0}};
                end else begin
                    state_n_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (sync_n_s) begin
                    state_n_s = IDLE;
                    cnt_n_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_n_s   = PRESSED;
                    cnt_n_s     = {CNT_W{1'b0}};
                    press_set_s = 1'b1;
                end else begin
                    cnt_n_s = cnt_r + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync_n_s) begin
                    state_n_s = RELEASE_WAIT;
                    cnt_n_s   = {CNT_W{1'b0}};
                end else begin
                    state_n_s = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_n_s) begin
                    state_n_s = PRESSED;
                    cnt_n_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_n_s     = IDLE;
                    cnt_n_s       = {CNT_W{1'b0}};
                    release_set_s = 1'b1;
                end else begin
                    cnt_n_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_n_s = IDLE;
                cnt_n_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 32'd1);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_n_s;
    logic              rep_phase_r;
    logic              rep_phase_n_s;

    // Hold/repeat counter registers.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            hold_cnt_r  <= {HOLD_W{1'b0}};
            rep_phase_r <= 1'b0;
        end else begin
            hold_cnt_r  <= hold_cnt_n_s;
            rep_phase_r <= rep_phase_n_s;
        end
    end

    // First strobe after the hold time, then one per repeat period while held.
    always_comb begin
        hold_cnt_n_s  = hold_cnt_r;
        rep_phase_n_s = rep_phase_r;
        rep_fire_s    = 1'b0;
        if ((state_r == PRESSED) && !sync_n_s) begin
            if (hold_cnt_r == (rep_phase_r ? REP_LAST : HOLD_LAST)) begin
                rep_fire_s    = 1'b1;
                hold_cnt_n_s  = {HOLD_W{1'b0}};
                rep_phase_n_s = 1'b1;
            end else begin
                hold_cnt_n_s = hold_cnt_r + HOLD_W'(1);
            end
        end else begin
            hold_cnt_n_s  = {HOLD_W{1'b0}};
            rep_phase_n_s = 1'b0;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Registered outputs; the level follows the state being entered.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            pressed_r       <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
        end else begin
            pressed_r       <= is_pressed_state(state_n_s);
            press_pulse_r   <= press_set_s | rep_fire_s;
            release_pulse_r <= release_set_s;
        end
    end

    assign pressed       = pressed_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected strobes are queued with their
// cycle when the key is driven and matched as the DUT emits them.
module tb_key_debounce;

    localparam int unsigned DEB  = 32'd4;
    localparam int unsigned HOLD = 32'd10;
    localparam int unsigned REP  = 32'd3;

    logic CLOCK_50 = 1'b0;
    logic KEY0;
    logic key_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t sb_q[$];

    key_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .KEY0          (KEY0),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Key reaches the FSM 3 edges after it is driven; press strobe 7 edges later,
    // repeats every REP edges once HOLD edges have been spent in PRESSED.
    task automatic press_track(input int n);
        int n0;
        n0 = cyc;
        push_exp(1, n0 + 7);
`ifdef KEY_DEBOUNCE_REPEAT_EN
        for (int k = int'(HOLD); k <= n - 5; k++) begin
            if (((k - int'(HOLD)) % int'(REP)) == 0) push_exp(1, n0 + 7 + k);
        end
`endif
        wait_cyc(6);
        check_val("press_early", 32'(pressed), 32'd0);
        wait_cyc(1);
        check_val("press_level", 32'(pressed), 32'd1);
        wait_cyc(n - 7);
    endtask

    task automatic press_low(input int n);
        key_n = 1'b0;
        press_track(n);
    endtask

    task automatic release_high(input int n);
        int n0;
        n0    = cyc;
        key_n = 1'b1;
        push_exp(2, n0 + 7);
        wait_cyc(6);
        check_val("release_early", 32'(pressed), 32'd1);
        wait_cyc(1);
        check_val("release_level", 32'(pressed), 32'd0);
        wait_cyc(n - 7);
    endtask

    // Strobe monitor: flags overdue, unexpected, misplaced or overlapping strobes.
    always @(negedge CLOCK_50) begin
        int   kind;
        exp_t e;
        kind = press_pulse ? 1 : (release_pulse ? 2 : 0);
        while ((sb_q.size() > 0) && (sb_q[0].at < cyc)) begin
            check_val("pulse_missed", 32'd0, 32'(sb_q[0].kind));
            void'(sb_q.pop_front());
        end
        if (press_pulse && release_pulse) check_val("pulse_excl", 32'd1, 32'd0);
        if (kind != 0) begin
            if (sb_q.size() == 0) begin
                check_val("pulse_unexpected", 32'(kind), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("pulse_kind", 32'(kind), 32'(e.kind));
                check_val("pulse_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        KEY0  = 1'b1;
        key_n = 1'b1;
        #1 KEY0 = 1'b0;
        #1;
        check_val("rst_pressed", 32'(pressed), 32'd0);
        check_val("rst_press_pulse", 32'(press_pulse), 32'd0);
        check_val("rst_release_pulse", 32'(release_pulse), 32'd0);
        wait_cyc(3);
        KEY0 = 1'b1;
        wait_cyc(5);
        check_val("idle_pressed", 32'(pressed), 32'd0);

        // Clean press and release.
        press_low(20);
        release_high(12);

        // Short low glitch must be rejected.
        key_n = 1'b0;
        wait_cyc(2);
        key_n = 1'b1;
        wait_cyc(10);
        check_val("glitch_press", 32'(pressed), 32'd0);

        // Bouncing press: low 2, high 1, then steady low.
        key_n = 1'b0;
        wait_cyc(2);
        key_n = 1'b1;
        wait_cyc(1);
        press_low(20);

        // Short high glitch while pressed must not release.
        key_n = 1'b1;
        wait_cyc(2);
        key_n = 1'b0;
        wait_cyc(8);
        check_val("glitch_release", 32'(pressed), 32'd1);
        release_high(12);

        // Reset one edge before the press strobe would fire; key stays held.
        key_n = 1'b0;
        wait_cyc(6);
        #2 KEY0 = 1'b0;
        #1;
        check_val("rst_pw_pressed", 32'(pressed), 32'd0);
        check_val("rst_pw_press_pulse", 32'(press_pulse), 32'd0);
        wait_cyc(3);
        KEY0 = 1'b1;
        press_track(12);
        release_high(12);

        // Reset while pressed drops the level immediately.
        press_low(10);
        #2 KEY0 = 1'b0;
        #1;
        check_val("rst_held_pressed", 32'(pressed), 32'd0);
        key_n = 1'b1;
        wait_cyc(3);
        KEY0 = 1'b1;
        wait_cyc(10);
        check_val("post_rst_pressed", 32'(pressed), 32'd0);

        // Long hold: auto-repeat strobes only when the feature is built in.
        press_low(35);
        release_high(12);

        wait_cyc(5);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
